// File: rtl/axi_master_interface.sv
// CPU-side AXI4 master bridge: one outstanding read or write (single beat or INCR burst),
// with byte-lane alignment and strobe generation. Optional define: AXI_MASTER_ALIGN_CHECK_EN.
module axi_master_interface #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [7:0]        req_len,
  input  logic [DATA_W-1:0] wbeat_data,
  input  logic              wbeat_valid,
  output logic              wbeat_ready,
  output logic [DATA_W-1:0] rbeat_data,
  output logic              rbeat_valid,
  input  logic              rbeat_ready,
  output logic              rbeat_last,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic [ID_W-1:0]   axi_ar_id_o,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  output logic [7:0]        axi_ar_len_o,
  output logic [2:0]        axi_ar_size_o,
  output logic [1:0]        axi_ar_burst_o,
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  input  logic [DATA_W-1:0] axi_r_data_i,
  input  logic [1:0]        axi_r_resp_i,
  input  logic              axi_r_last_i,
  input  logic              axi_r_valid_i,
  output logic              axi_r_ready_o,
  output logic [ID_W-1:0]   axi_aw_id_o,
  output logic [ADDR_W-1:0] axi_aw_addr_o,
  output logic [7:0]        axi_aw_len_o,
  output logic [2:0]        axi_aw_size_o,
  output logic [1:0]        axi_aw_burst_o,
  output logic              axi_aw_valid_o,
  input  logic              axi_aw_ready_i,
  output logic [DATA_W-1:0] axi_w_data_o,
  output logic [7:0]        axi_w_strb_o,
  output logic              axi_w_last_o,
  output logic              axi_w_valid_o,
  input  logic              axi_w_ready_i,
  input  logic [1:0]        axi_b_resp_i,
  input  logic              axi_b_valid_i,
  output logic              axi_b_ready_o
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] start_addr, beat_addr;
  logic [2:0]        size_q;
  logic [7:0]        len_q, beat_cnt;
  logic [1:0]        worst_resp, resp_max;
  logic              ar_valid_q, aw_valid_q;
  logic [DATA_W-1:0] size_mask;
  logic [7:0]        strb;
  logic [5:0]        lane_shift;
  logic              r_hs, w_hs, w_last;

  assign lane_shift = {beat_addr[2:0], 3'b000};
  assign r_hs       = (state == RDATA) && axi_r_valid_i && rbeat_ready;
  assign w_hs       = (state == WDATA) && wbeat_valid && axi_w_ready_i;
  assign w_last     = (beat_cnt == len_q);
  assign resp_max   = (axi_r_resp_i > worst_resp) ? axi_r_resp_i : worst_resp;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    size_mask = '1;
    strb      = 8'hFF;
    case (size_q)
      3'd0: begin size_mask = DATA_W'(64'hFF);       strb = 8'h01 << beat_addr[2:0]; end
      3'd1: begin size_mask = DATA_W'(64'hFFFF);     strb = 8'h03 << beat_addr[2:0]; end
      3'd2: begin size_mask = DATA_W'(64'hFFFF_FFFF); strb = 8'h0F << beat_addr[2:0]; end
      default: ;
    endcase
  end

`ifdef AXI_MASTER_ALIGN_CHECK_EN
  logic [2:0] align_mask;
  logic       misaligned;
  always_comb begin
    align_mask = 3'b111;
    case (req_size)
      3'd0: align_mask = 3'b000;
      3'd1: align_mask = 3'b001;
      3'd2: align_mask = 3'b011;
      default: ;
    endcase
  end
  assign misaligned = |(req_addr[2:0] & align_mask);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_addr <= '0;
      beat_addr  <= '0;
      size_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      worst_resp <= '0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          start_addr <= req_addr;
          beat_addr  <= req_addr;
          size_q     <= req_size;
          len_q      <= req_len;
          beat_cnt   <= '0;
          worst_resp <= '0;
`ifdef AXI_MASTER_ALIGN_CHECK_EN
          if (misaligned) begin
            done_valid <= 1'b1;
            done_resp  <= 2'b10;
          end else
`endif
          if (req_wen) begin
            state      <= WADDR;
            aw_valid_q <= 1'b1;
          end else begin
            state      <= RADDR;
            ar_valid_q <= 1'b1;
          end
        end
        RADDR: if (axi_ar_ready_i) begin
          ar_valid_q <= 1'b0;
          state      <= RDATA;
        end
        RDATA: if (r_hs) begin
          beat_addr  <= beat_addr + (ADDR_W'(1) << size_q);
          beat_cnt   <= beat_cnt + 8'd1;
          worst_resp <= resp_max;
          if (axi_r_last_i) begin
            // A last beat before the requested length is reported as SLVERR.
            done_valid <= 1'b1;
            done_resp  <= (beat_cnt != len_q) ? 2'b10 : resp_max;
            state      <= IDLE;
          end
        end
        WADDR: if (axi_aw_ready_i) begin
          aw_valid_q <= 1'b0;
          state      <= WDATA;
        end
        WDATA: if (w_hs) begin
          beat_addr <= beat_addr + (ADDR_W'(1) << size_q);
          beat_cnt  <= beat_cnt + 8'd1;
          if (w_last) state <= WRESP;
        end
        WRESP: if (axi_b_valid_i) begin
          done_valid <= 1'b1;
          done_resp  <= axi_b_resp_i;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // req_ready is held low while reset is asserted so every ready output is quiet in reset.
  assign req_ready      = (state == IDLE) && rst;

  assign axi_ar_id_o    = AXI_ID;
  assign axi_ar_addr_o  = start_addr;
  assign axi_ar_len_o   = len_q;
  assign axi_ar_size_o  = size_q;
  assign axi_ar_burst_o = 2'b01;
  assign axi_ar_valid_o = ar_valid_q;
  assign axi_r_ready_o  = (state == RDATA) && rbeat_ready;
  assign rbeat_valid    = (state == RDATA) && axi_r_valid_i;
  assign rbeat_last     = (state == RDATA) && axi_r_last_i;
  assign rbeat_data     = (axi_r_data_i >> lane_shift) & size_mask;

  assign axi_aw_id_o    = AXI_ID;
  assign axi_aw_addr_o  = start_addr;
  assign axi_aw_len_o   = len_q;
  assign axi_aw_size_o  = size_q;
  assign axi_aw_burst_o = 2'b01;
  assign axi_aw_valid_o = aw_valid_q;
  assign axi_w_valid_o  = (state == WDATA) && wbeat_valid;
  assign wbeat_ready    = (state == WDATA) && axi_w_ready_i;
  assign axi_w_data_o   = wbeat_data << lane_shift;
  assign axi_w_strb_o   = strb;
  assign axi_w_last_o   = (state == WDATA) && w_last;
  assign axi_b_ready_o  = (state == WRESP);

endmodule

// File: tb/tb_axi_master_interface.sv
// Directed bench for axi_master_interface: single-beat vector table plus burst, reset,
// early-last and misalignment sequences. Honours AXI_MASTER_ALIGN_CHECK_EN if defined.
module tb_axi_master_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic [63:0] wbeat_data, rbeat_data;
  logic        wbeat_valid, wbeat_ready, rbeat_valid, rbeat_ready, rbeat_last;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  axi_ar_id_o, axi_aw_id_o;
  logic [63:0] axi_ar_addr_o, axi_aw_addr_o;
  logic [7:0]  axi_ar_len_o, axi_aw_len_o;
  logic [2:0]  axi_ar_size_o, axi_aw_size_o;
  logic [1:0]  axi_ar_burst_o, axi_aw_burst_o;
  logic        axi_ar_valid_o, axi_ar_ready_i, axi_aw_valid_o, axi_aw_ready_i;
  logic [63:0] axi_r_data_i, axi_w_data_o;
  logic [1:0]  axi_r_resp_i, axi_b_resp_i;
  logic        axi_r_last_i, axi_r_valid_i, axi_r_ready_o;
  logic [7:0]  axi_w_strb_o;
  logic        axi_w_last_o, axi_w_valid_o, axi_w_ready_i;
  logic        axi_b_valid_i, axi_b_ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_master_interface dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .wbeat_data(wbeat_data), .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready),
    .rbeat_data(rbeat_data), .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready),
    .rbeat_last(rbeat_last), .done_valid(done_valid), .done_resp(done_resp),
    .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o)
  );

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] din;
    logic [1:0]  resp;
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one request for a cycle; returns on the following negedge.
  task automatic send_req(input logic wen, input logic [63:0] addr, input logic [2:0] size,
                          input logic [7:0] len);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size; req_len = len;
    #1 check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic ar_hs(input string tag, input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] l);
    #1;
    check({tag, "_ar_valid"}, axi_ar_valid_o, 1);
    check({tag, "_ar_addr"},  axi_ar_addr_o, a);
    check({tag, "_ar_len"},   axi_ar_len_o, l);
    check({tag, "_ar_size"},  axi_ar_size_o, s);
    check({tag, "_ar_burst"}, axi_ar_burst_o, 2'b01);
    check({tag, "_ar_id"},    axi_ar_id_o, 0);
    axi_ar_ready_i = 1'b1;
    @(negedge clk);
    axi_ar_ready_i = 1'b0;
  endtask

  task automatic aw_hs(input string tag, input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] l, input int delay);
    for (int k = 0; k < delay; k++) begin
      #1;
      check({tag, "_aw_wait_valid"}, axi_aw_valid_o, 1);
      check({tag, "_w_valid_early"}, axi_w_valid_o, 0);
      check({tag, "_wbeat_ready_early"}, wbeat_ready, 0);
      @(negedge clk);
    end
    #1;
    check({tag, "_aw_valid"}, axi_aw_valid_o, 1);
    check({tag, "_aw_addr"},  axi_aw_addr_o, a);
    check({tag, "_aw_len"},   axi_aw_len_o, l);
    check({tag, "_aw_size"},  axi_aw_size_o, s);
    check({tag, "_aw_burst"}, axi_aw_burst_o, 2'b01);
    check({tag, "_w_valid_pre_aw"}, axi_w_valid_o, 0);
    axi_aw_ready_i = 1'b1;
    @(negedge clk);
    axi_aw_ready_i = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [63:0] d, input logic [1:0] resp,
                        input logic last, input logic [63:0] exp_d);
    axi_r_valid_i = 1'b1; axi_r_data_i = d; axi_r_resp_i = resp; axi_r_last_i = last;
    rbeat_ready = 1'b1;
    #1;
    check({tag, "_rbeat_valid"}, rbeat_valid, 1);
    check({tag, "_rbeat_data"},  rbeat_data, exp_d);
    check({tag, "_rbeat_last"},  rbeat_last, last);
    check({tag, "_r_ready"},     axi_r_ready_o, 1);
    @(negedge clk);
    axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0; rbeat_ready = 1'b0;
  endtask

  task automatic w_beat(input string tag, input logic [63:0] d, input logic [63:0] exp_d,
                        input logic [7:0] exp_strb, input logic exp_last);
    wbeat_data = d; wbeat_valid = 1'b1; axi_w_ready_i = 1'b1;
    #1;
    check({tag, "_w_valid"},     axi_w_valid_o, 1);
    check({tag, "_w_data"},      axi_w_data_o, exp_d);
    check({tag, "_w_strb"},      axi_w_strb_o, exp_strb);
    check({tag, "_w_last"},      axi_w_last_o, exp_last);
    check({tag, "_wbeat_ready"}, wbeat_ready, 1);
    @(negedge clk);
    wbeat_valid = 1'b0; axi_w_ready_i = 1'b0;
  endtask

  task automatic b_beat(input string tag, input logic [1:0] resp);
    #1 check({tag, "_b_ready"}, axi_b_ready_o, 1);
    axi_b_valid_i = 1'b1; axi_b_resp_i = resp;
    @(negedge clk);
    axi_b_valid_i = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [1:0] exp_resp);
    #1;
    check({tag, "_done_valid"}, done_valid, 1);
    check({tag, "_done_resp"},  done_resp, exp_resp);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse_end"}, done_valid, 0);
    check({tag, "_back_idle"},      req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int beats, cyc;
    logic [63:0] bd;

    rst = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = '0; req_size = '0; req_len = '0;
    wbeat_data = '0; wbeat_valid = 0; rbeat_ready = 0;
    axi_ar_ready_i = 0; axi_aw_ready_i = 0; axi_w_ready_i = 0;
    axi_r_data_i = '0; axi_r_resp_i = '0; axi_r_last_i = 0; axi_r_valid_i = 0;
    axi_b_resp_i = '0; axi_b_valid_i = 0;

    //              wen   addr            size  din                     resp   exp_data                exp_strb exp_resp
    vecs[0] = '{1'b0, 64'h8000_0004, 3'd2, 64'h1122334455667788, 2'd0, 64'h11223344,          8'h00, 2'd0};
    vecs[1] = '{1'b0, 64'h8000_0001, 3'd0, 64'h1122334455667788, 2'd0, 64'h77,                8'h00, 2'd0};
    vecs[2] = '{1'b0, 64'h8000_0006, 3'd1, 64'h1122334455667788, 2'd1, 64'h1122,              8'h00, 2'd1};
    vecs[3] = '{1'b0, 64'h8000_0000, 3'd3, 64'h1122334455667788, 2'd0, 64'h1122334455667788, 8'h00, 2'd0};
    vecs[4] = '{1'b1, 64'h8000_0003, 3'd0, 64'hAB,               2'd0, 64'h00000000AB000000, 8'h08, 2'd0};
    vecs[5] = '{1'b1, 64'h8000_0002, 3'd1, 64'hBEEF,             2'd2, 64'h00000000BEEF0000, 8'h0C, 2'd2};
    vecs[6] = '{1'b1, 64'h8000_0004, 3'd2, 64'hDEADBEEF,         2'd0, 64'hDEADBEEF00000000, 8'hF0, 2'd0};
    vecs[7] = '{1'b1, 64'h8000_0000, 3'd3, 64'h0123456789ABCDEF, 2'd0, 64'h0123456789ABCDEF, 8'hFF, 2'd0};

    // Reset state.
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_req_ready",  req_ready, 0);
    check("rst_ar_valid",   axi_ar_valid_o, 0);
    check("rst_aw_valid",   axi_aw_valid_o, 0);
    check("rst_w_valid",    axi_w_valid_o, 0);
    check("rst_w_last",     axi_w_last_o, 0);
    check("rst_r_ready",    axi_r_ready_o, 0);
    check("rst_b_ready",    axi_b_ready_o, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_resp",  done_resp, 0);
    check("rst_ar_addr",    axi_ar_addr_o, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_rst_req_ready", req_ready, 1);

    // Single-beat table.
    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      send_req(vecs[i].wen, vecs[i].addr, vecs[i].size, 8'd0);
      if (!vecs[i].wen) begin
        ar_hs(tag, vecs[i].addr, vecs[i].size, 8'd0);
        r_beat(tag, vecs[i].din, vecs[i].resp, 1'b1, vecs[i].exp_data);
      end else begin
        aw_hs(tag, vecs[i].addr, vecs[i].size, 8'd0, 0);
        w_beat(tag, vecs[i].din, vecs[i].exp_data, vecs[i].exp_strb, 1'b1);
        b_beat(tag, vecs[i].resp);
      end
      check_done(tag, vecs[i].exp_resp);
    end

    // Read burst, len 3, core backpressure every other cycle; beat 2 returns EXOKAY.
    send_req(1'b0, 64'h8000_0000, 3'd3, 8'd3);
    req_valid = 1'b1;
    #1 check("busy_req_ready", req_ready, 0);
    req_valid = 1'b0;
    ar_hs("rburst", 64'h8000_0000, 3'd3, 8'd3);
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 20) begin
      bd = 64'h1111_1111_1111_1111 * (beats + 1);
      axi_r_valid_i = 1'b1; axi_r_data_i = bd;
      axi_r_resp_i = (beats == 2) ? 2'd1 : 2'd0;
      axi_r_last_i = (beats == 3);
      rbeat_ready = (cyc % 2 == 0);
      #1;
      check("rburst_r_ready_mirror", axi_r_ready_o, rbeat_ready);
      if (rbeat_ready) begin
        check($sformatf("rburst_b%0d_data", beats), rbeat_data, bd);
        check($sformatf("rburst_b%0d_last", beats), rbeat_last, (beats == 3));
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0; rbeat_ready = 1'b0;
    check("rburst_beat_count", beats, 4);
    check_done("rburst", 2'd1);

    // Write burst, len 1, size 3, AW ready held off 5 cycles with W side ready.
    send_req(1'b1, 64'h8000_0040, 3'd3, 8'd1);
    wbeat_valid = 1'b1; axi_w_ready_i = 1'b1; wbeat_data = 64'hFEED;
    aw_hs("wburst", 64'h8000_0040, 3'd3, 8'd1, 5);
    w_beat("wburst_b0", 64'hA5A5_0000_1234_5678, 64'hA5A5_0000_1234_5678, 8'hFF, 1'b0);
    w_beat("wburst_b1", 64'h5A5A_FFFF_8765_4321, 64'h5A5A_FFFF_8765_4321, 8'hFF, 1'b1);
    b_beat("wburst", 2'd0);
    check_done("wburst", 2'd0);

    // Narrow write burst: beat address advances 0x4 -> 0x8, lanes move accordingly.
    send_req(1'b1, 64'h8000_0004, 3'd2, 8'd1);
    aw_hs("wnarrow", 64'h8000_0004, 3'd2, 8'd1, 0);
    w_beat("wnarrow_b0", 64'h1111_1111, 64'h1111_1111_0000_0000, 8'hF0, 1'b0);
    w_beat("wnarrow_b1", 64'h2222_2222, 64'h0000_0000_2222_2222, 8'h0F, 1'b1);
    b_beat("wnarrow", 2'd3);
    check_done("wnarrow", 2'd3);

    // Early last on a len-3 read forces SLVERR.
    send_req(1'b0, 64'h8000_0200, 3'd3, 8'd3);
    ar_hs("early", 64'h8000_0200, 3'd3, 8'd3);
    r_beat("early", 64'hCAFE_F00D_0000_0001, 2'd0, 1'b1, 64'hCAFE_F00D_0000_0001);
    check_done("early", 2'd2);

    // Misaligned read (addr ...2, size 2).
    send_req(1'b0, 64'h8000_0002, 3'd2, 8'd0);
`ifdef AXI_MASTER_ALIGN_CHECK_EN
    #1;
    check("misalign_no_ar", axi_ar_valid_o, 0);
    check_done("misalign", 2'd2);
`else
    ar_hs("misalign", 64'h8000_0002, 3'd2, 8'd0);
    r_beat("misalign", 64'h1122334455667788, 2'd0, 1'b1, 64'h33445566);
    check_done("misalign", 2'd0);
`endif

    // Reset asserted mid-WDATA.
    send_req(1'b1, 64'h8000_0100, 3'd3, 8'd3);
    aw_hs("rstw", 64'h8000_0100, 3'd3, 8'd3, 0);
    wbeat_valid = 1'b1; axi_w_ready_i = 1'b0;
    #1 check("rstw_w_valid_before", axi_w_valid_o, 1);
    rst = 1'b0;
    axi_w_ready_i = 1'b1;
    #1;
    check("rstw_w_valid",     axi_w_valid_o, 0);
    check("rstw_wbeat_ready", wbeat_ready, 0);
    check("rstw_w_last",      axi_w_last_o, 0);
    check("rstw_aw_valid",    axi_aw_valid_o, 0);
    check("rstw_req_ready",   req_ready, 0);
    @(negedge clk);
    rst = 1'b1; wbeat_valid = 1'b0; axi_w_ready_i = 1'b0;
    #1;
    check("rstw_idle_req_ready", req_ready, 1);
    check("rstw_idle_b_ready",   axi_b_ready_o, 0);

    // Post-reset transaction still works.
    send_req(1'b0, 64'h8000_0004, 3'd2, 8'd0);
    ar_hs("postrst", 64'h8000_0004, 3'd2, 8'd0);
    r_beat("postrst", 64'h1122334455667788, 2'd0, 1'b1, 64'h11223344);
    check_done("postrst", 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_interface.md
Name: axi_master_interface

Overview:
- CPU-side AXI4 master bridge.
- Accepts simple read/write requests from the core memory stage (single beat or incrementing burst) and drives the AXI AR/R/AW/W/B channels toward the SoC SRAM slave.
- Performs byte-lane alignment and strobe generation for narrow (8/16/32-bit) accesses.
- Serializes transactions: one outstanding transaction at a time.

Parameters:
- ADDR_W, 64, AXI and request address width.
- DATA_W, 64, AXI data width; fixed 64 (8 byte lanes).
- ID_W, 4, AXI ID width; all IDs driven with the constant AXI_ID.
- AXI_ID, 0, ID value placed on axi_ar_id_o/axi_aw_id_o.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (ARESETn semantics).
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted this cycle.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start byte address.
- req_size  in  3  0/1/2/3 = 1/2/4/8 bytes per beat.
- req_len  in  8  beats minus 1 (AXI len).
- wbeat_data  in  64  write beat data, right-justified (LSB-aligned).
- wbeat_valid  in  1  write beat valid.
- wbeat_ready  out  1  write beat consumed.
- rbeat_data  out  64  read beat data, right-justified, zero-extended.
- rbeat_valid  out  1  read beat valid.
- rbeat_ready  in  1  core accepts read beat.
- rbeat_last  out  1  final read beat.
- done_valid  out  1  one-cycle pulse: transaction complete.
- done_resp  out  2  R (worst of burst) or B response.
- axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o  out  ID_W/ADDR_W/8/3/2  AR payload.
- axi_ar_valid_o  out  1; axi_ar_ready_i  in  1.
- axi_r_data_i  in  64; axi_r_resp_i  in  2; axi_r_last_i  in  1; axi_r_valid_i  in  1; axi_r_ready_o  out  1.
- axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o  out  ID_W/ADDR_W/8/3/2  AW payload.
- axi_aw_valid_o  out  1; axi_aw_ready_i  in  1.
- axi_w_data_o  out  64; axi_w_strb_o  out  8; axi_w_last_o  out  1; axi_w_valid_o  out  1; axi_w_ready_i  in  1.
- axi_b_resp_i  in  2; axi_b_valid_i  in  1; axi_b_ready_o  out  1.

Behaviour:
- Reset (rst low, async): state IDLE; every valid/ready/last/done output 0; all payload registers 0; done_resp 0.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE: req_ready=1. On req_valid, capture addr/size/len/wen, then go to WADDR (wen=1) or RADDR (wen=0). Request-to-AR/AW-valid latency is 1 cycle.
- RADDR: axi_ar_valid_o held with stable payload until axi_ar_ready_i; then RDATA. burst fixed 2'b01 (INCR).
- RDATA: axi_r_ready_o = rbeat_ready (pass-through backpressure). rbeat_valid = axi_r_valid_i.
  - rbeat_data = axi_r_data_i >> (8*beat_addr[2:0]), masked to size.
  - beat_addr starts at req_addr and advances by 1<<size per accepted beat.
  - Worst response kept as max(resp). On handshake with axi_r_last_i: done_valid pulse next cycle with done_resp, then IDLE.
  - rbeat_last = axi_r_last_i.
- WADDR: axi_aw_valid_o until axi_aw_ready_i; then WDATA.
- WDATA: axi_w_valid_o = wbeat_valid; wbeat_ready = axi_w_ready_i.
  - axi_w_data_o = wbeat_data << (8*beat_addr[2:0]).
  - Strobe: size0 = 1<<a; size1 = 2'b11<<a; size2 = 4'hF<<a (a = beat_addr[2:0], size-aligned); size3 = 8'hFF.
  - Beat counter compares against len; axi_w_last_o=1 on beat len. After the last handshake, go to WRESP.
- WRESP: axi_b_ready_o=1; on axi_b_valid_i, done_valid pulse with axi_b_resp_i, then IDLE.
- Write data never issued before AW handshake.
- len=0: single beat; last asserted on first beat.
- Beat address wrap: arithmetic in ADDR_W bits, modulo 2^ADDR_W; no 4 KB boundary check (core guarantees).
- R beat arriving with last before len beats: accepted, transaction ends; done_resp forced to 2'b10.
- req_valid during a busy state: ignored (req_ready=0).

Optional Feature:
- Macro: AXI_MASTER_ALIGN_CHECK_EN.
- Defined: in IDLE, a request whose req_addr is not aligned to 1<<req_size is accepted but no AXI traffic is issued. done_valid pulses 1 cycle later with done_resp=2'b10.
- Undefined: no check; misaligned address is issued as-is and strobe/shift use the raw low address bits.

Test Plan:
- Read, addr 0x8000_0004, size 2, len 0; slave returns data 0x1122334455667788 → AR addr 0x80000004/len0/size2/burst1; rbeat_data=0x11223344, rbeat_last=1; done_resp 0.
- Write, addr 0x8000_0003, size 0, data 0xAB → axi_w_data_o=0x00000000AB000000, strb 8'h08, last 1; B OKAY → done_valid, resp 0.
- Read burst, addr 0x8000_0000, size 3, len 3; rbeat_ready low every other cycle → 4 beats delivered in order; axi_r_ready_o mirrors rbeat_ready; last only on beat 4.
- Write burst, len 1, size 3; AW ready delayed 5 cycles → no W valid before AW handshake; strb 8'hFF both beats; last on beat 2.
- Reset asserted mid-WDATA → all valid outputs drop immediately; after release, state IDLE with req_ready=1.
- With AXI_MASTER_ALIGN_CHECK_EN: read addr 0x...2, size 2 → no AR valid; done_resp=2'b10 one cycle later. Without the macro: AR issued at 0x...2.
